// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the Pong match sequencer and its surroundings:
// VGA frame timing and ball/paddle events in, ball control and score out.
interface pong_match_ctrl_if;
  logic       frame_clk;
  logic       start;
  logic       miss_l;
  logic       miss_r;
  logic       hit_l;
  logic       hit_r;
  logic       ball_hold;
  logic       serve_dir;
  logic [3:0] l_score;
  logic [3:0] r_score;
  logic [1:0] speed_level;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output frame_clk, start, miss_l, miss_r, hit_l, hit_r,
    input  ball_hold, serve_dir, l_score, r_score, speed_level, winner, state
  );

  modport slave (
    input  frame_clk, start, miss_l, miss_r, hit_l, hit_r,
    output ball_hold, serve_dir, l_score, r_score, speed_level, winner, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: edge-detects start/miss/hit/frame events and runs
// the IDLE -> SERVE -> PLAY -> POINT -> GAMEOVER match flow, keeping the
// scores and declaring the winner.
// Optional feature: define PONG_SPEEDUP_EN to build the rally hit counter
// that drives speed_level; without it hit_l/hit_r are ignored and
// speed_level is tied to 0.
module pong_match_ctrl #(
  parameter int WIN_SCORE      = 7,
  parameter int SERVE_FRAMES   = 60,
  parameter int HITS_PER_LEVEL = 4
) (
  input logic              Clk,
  input logic              Reset_n,
  pong_match_ctrl_if.slave io
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SERVE    = 3'd1;
  localparam logic [2:0] PLAY     = 3'd2;
  localparam logic [2:0] POINT    = 3'd3;
  localparam logic [2:0] GAMEOVER = 3'd4;

  // Event bit positions in the conditioning pipeline.
  localparam int EV_FRAME  = 0;
  localparam int EV_START  = 1;
  localparam int EV_MISS_L = 2;
  localparam int EV_MISS_R = 3;

`ifdef PONG_SPEEDUP_EN
  localparam int EV_HIT_L = 4;
  localparam int EV_HIT_R = 5;
  localparam int N_IN     = 6;
`else
  localparam int N_IN     = 4;
`endif

  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] sync_q;
  logic [N_IN-1:0] prev_q;
  logic [N_IN-1:0] evt_q;

`ifdef PONG_SPEEDUP_EN
  assign raw_in = {io.hit_r, io.hit_l, io.miss_r, io.miss_l, io.start, io.frame_clk};
`else
  assign raw_in = {io.miss_r, io.miss_l, io.start, io.frame_clk};
`endif

  // Register inputs, keep their previous value and register one-cycle pulses:
  // rising edges for the event inputs, falling edge for the active-low vsync.
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // rather than in the sensitivity list.
    if (!Reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      evt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make prev_q capture the old sync_q,
      // which is exactly what the edge compare needs.
      sync_q <= raw_in;
      prev_q <= sync_q;
      evt_q  <= {sync_q[N_IN-1:1] & ~prev_q[N_IN-1:1],
                 prev_q[EV_FRAME] & ~sync_q[EV_FRAME]};
    end
  end

  logic frame_tick, start_ev, miss_l_ev, miss_r_ev;
  assign frame_tick = evt_q[EV_FRAME];
  assign start_ev   = evt_q[EV_START];
  assign miss_l_ev  = evt_q[EV_MISS_L];
  assign miss_r_ev  = evt_q[EV_MISS_R];

  logic [2:0] state_q;
  logic       ball_hold_q;
  logic       serve_dir_q;
  logic [3:0] l_score_q;
  logic [3:0] r_score_q;
  logic [1:0] winner_q;
  logic [7:0] count_q;
  logic       point_won;

  // serve_dir doubles as "who lost the last point": 1 means the right side scored.
  assign point_won = serve_dir_q ? (r_score_q == 4'(WIN_SCORE))
                                 : (l_score_q == 4'(WIN_SCORE));

  // Match state machine; ball_hold is registered alongside the next state.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      ball_hold_q <= 1'b1;
      serve_dir_q <= 1'b0;
      l_score_q   <= 4'd0;
      r_score_q   <= 4'd0;
      winner_q    <= 2'b00;
      count_q     <= 8'd0;
    end else begin
      case (state_q)
        IDLE, GAMEOVER: begin
          if (start_ev) begin
            l_score_q   <= 4'd0;
            r_score_q   <= 4'd0;
            winner_q    <= 2'b00;
            serve_dir_q <= 1'b0;
            count_q     <= 8'(SERVE_FRAMES);
            state_q     <= SERVE;
            ball_hold_q <= 1'b1;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            count_q <= count_q - 8'd1;
            if (count_q == 8'd1) begin
              state_q     <= PLAY;
              ball_hold_q <= 1'b0;
            end
          end
        end
        PLAY: begin
          if (miss_l_ev) begin
            r_score_q   <= r_score_q + 4'd1;
            serve_dir_q <= 1'b1;
            state_q     <= POINT;
            ball_hold_q <= 1'b1;
          end else if (miss_r_ev) begin
            l_score_q   <= l_score_q + 4'd1;
            serve_dir_q <= 1'b0;
            state_q     <= POINT;
            ball_hold_q <= 1'b1;
          end
        end
        POINT: begin
          ball_hold_q <= 1'b1;
          if (point_won) begin
            winner_q <= serve_dir_q ? 2'b10 : 2'b01;
            state_q  <= GAMEOVER;
          end else begin
            count_q <= 8'(SERVE_FRAMES);
            state_q <= SERVE;
          end
        end
        default: begin
          state_q     <= IDLE;
          ball_hold_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [3:0] rally_q;
  logic [3:0] rally_inc;
  logic [1:0] speed_q;
  logic       hit_ev;

  assign hit_ev    = evt_q[EV_HIT_L] | evt_q[EV_HIT_R];
  assign rally_inc = (rally_q == 4'hF) ? 4'hF : rally_q + 4'd1;

  function automatic logic [1:0] level_of(input logic [3:0] hits);
    logic [3:0] quo;
    quo = hits / 4'(HITS_PER_LEVEL);
    return (quo > 4'd3) ? 2'd3 : quo[1:0];
  endfunction

  // Rally hit counter and speed level: count hits in PLAY, clear on point or new match.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rally_q <= 4'd0;
      speed_q <= 2'd0;
    end else if (state_q == POINT ||
                 (start_ev && (state_q == IDLE || state_q == GAMEOVER))) begin
      rally_q <= 4'd0;
      speed_q <= 2'd0;
    end else if (state_q == PLAY && hit_ev) begin
      rally_q <= rally_inc;
      speed_q <= level_of(rally_inc);
    end
  end

  assign io.speed_level = speed_q;
`else
  assign io.speed_level = 2'd0;
`endif

  assign io.state     = state_q;
  assign io.ball_hold = ball_hold_q;
  assign io.serve_dir = serve_dir_q;
  assign io.l_score   = l_score_q;
  assign io.r_score   = r_score_q;
  assign io.winner    = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed scenarios followed by a
// random walk of events, compared against a transaction-level match model.
module tb_pong_match_ctrl;

  localparam int WIN   = 3;
  localparam int FRAMES = 2;
  localparam int HPL   = 2;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

`ifdef PONG_SPEEDUP_EN
  localparam int LVL_AFTER2 = 1;
  localparam int LVL_AFTER4 = 2;
`else
  localparam int LVL_AFTER2 = 0;
  localparam int LVL_AFTER4 = 0;
`endif

  logic clk;
  logic rst_n;
  pong_match_ctrl_if io ();

  pong_match_ctrl #(
    .WIN_SCORE     (WIN),
    .SERVE_FRAMES  (FRAMES),
    .HITS_PER_LEVEL(HPL)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .io     (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int point_cycles = 0;

  // Reference model: match situation after each whole event.
  int m_state, m_l, m_r, m_dir, m_hits, m_level, m_winner, m_frames;

  always @(negedge clk) if (io.state == 3'(S_POINT)) point_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = S_IDLE; m_l = 0; m_r = 0; m_dir = 0;
    m_hits = 0; m_level = 0; m_winner = 0; m_frames = 0;
  endfunction

  function automatic void model_step(input bit ev_start, input bit ev_tick,
                                     input bit ev_ml, input bit ev_mr, input bit ev_hit);
    case (m_state)
      S_IDLE, S_OVER: if (ev_start) begin
        m_l = 0; m_r = 0; m_hits = 0; m_level = 0; m_dir = 0; m_winner = 0;
        m_state = S_SERVE; m_frames = FRAMES;
      end
      S_SERVE: if (ev_tick) begin
        m_frames--;
        if (m_frames == 0) m_state = S_PLAY;
      end
      S_PLAY: begin
        if (ev_ml || ev_mr) begin
          if (ev_ml) begin m_r++; m_dir = 1; end
          else       begin m_l++; m_dir = 0; end
          m_hits = 0; m_level = 0;
          if ((ev_ml ? m_r : m_l) == WIN) begin
            m_winner = ev_ml ? 2 : 1;
            m_state  = S_OVER;
          end else begin
            m_state  = S_SERVE;
            m_frames = FRAMES;
          end
        end else if (ev_hit) begin
`ifdef PONG_SPEEDUP_EN
          m_hits  = (m_hits < 15) ? m_hits + 1 : 15;
          m_level = (m_hits / HPL > 3) ? 3 : m_hits / HPL;
`endif
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".state"},     32'(io.state),       32'(m_state));
    check({tag, ".ball_hold"}, 32'(io.ball_hold),   32'(m_state != S_PLAY));
    check({tag, ".serve_dir"}, 32'(io.serve_dir),   32'(m_dir));
    check({tag, ".l_score"},   32'(io.l_score),     32'(m_l));
    check({tag, ".r_score"},   32'(io.r_score),     32'(m_r));
    check({tag, ".speed"},     32'(io.speed_level), 32'(m_level));
    check({tag, ".winner"},    32'(io.winner),      32'(m_winner));
  endtask

  task automatic idle_inputs();
    io.start = 1'b0; io.frame_clk = 1'b1;
    io.miss_l = 1'b0; io.miss_r = 1'b0;
    io.hit_l = 1'b0; io.hit_r = 1'b0;
  endtask

  // kind: 0 start, 1 frame tick, 2 miss_l, 3 miss_r, 4 both misses, 5 hit_l, 6 hit_r
  task automatic act(input int kind, input int hold, input string tag);
    @(negedge clk);
    case (kind)
      0: io.start = 1'b1;
      1: io.frame_clk = 1'b0;
      2: io.miss_l = 1'b1;
      3: io.miss_r = 1'b1;
      4: begin io.miss_l = 1'b1; io.miss_r = 1'b1; end
      5: io.hit_l = 1'b1;
      6: io.hit_r = 1'b1;
      default: ;
    endcase
    repeat (hold) @(negedge clk);
    idle_inputs();
    model_step(kind == 0, kind == 1, kind == 2 || kind == 4, kind == 3,
               kind == 5 || kind == 6);
    repeat (4) @(negedge clk);
    check_all(tag);
  endtask

  task automatic serve_out();
    act(1, 1, "tick");
    act(1, 1, "tick");
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start event latency: SERVE appears at the second edge after sampling.
    @(negedge clk) io.start = 1'b1;
    @(negedge clk) io.start = 1'b0;
    @(negedge clk) check("start_lat_early", 32'(io.state), 32'(S_IDLE));
    @(negedge clk) check("start_lat", 32'(io.state), 32'(S_SERVE));
    model_step(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_all("after_start");

    // Serve countdown: first tick keeps SERVE, second tick releases the ball.
    act(1, 1, "tick1");
    @(negedge clk) io.frame_clk = 1'b0;
    @(negedge clk);
    @(negedge clk) check("play_lat_early", 32'(io.state), 32'(S_SERVE));
    @(negedge clk) begin
      check("play_lat", 32'(io.state), 32'(S_PLAY));
      check("play_hold", 32'(io.ball_hold), 32'd0);
    end
    io.frame_clk = 1'b1;
    model_step(0, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_all("in_play");

    // Five hits in one rally.
    act(5, 1, "hit1");
    act(6, 2, "hit2");
    check("lvl_hit2", 32'(io.speed_level), 32'(LVL_AFTER2));
    act(5, 1, "hit3");
    act(6, 1, "hit4");
    check("lvl_hit4", 32'(io.speed_level), 32'(LVL_AFTER4));
    act(5, 3, "hit5");

    // Long miss_r level: one point only, then SERVE toward the right.
    begin
      int p0;
      p0 = point_cycles;
      act(3, 100, "miss_r_hold");
      check("point_once", 32'(point_cycles - p0), 32'd1);
      check("lvl_cleared", 32'(io.speed_level), 32'd0);
    end

    // Simultaneous misses: left miss wins.
    serve_out();
    act(4, 1, "both_miss");
    check("both_r", 32'(io.r_score), 32'd1);
    check("both_dir", 32'(io.serve_dir), 32'd1);

    // Build 2-1 and reset mid-rally.
    serve_out();
    act(3, 1, "to_2_1");
    serve_out();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) begin
      check("rst_state", 32'(io.state), 32'(S_IDLE));
      check("rst_l", 32'(io.l_score), 32'd0);
      check("rst_r", 32'(io.r_score), 32'd0);
      check("rst_hold", 32'(io.ball_hold), 32'd1);
      check("rst_winner", 32'(io.winner), 32'd0);
    end
    model_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Right wins 3-0, then restart.
    act(0, 1, "start2");
    for (int i = 0; i < WIN; i++) begin
      serve_out();
      act(2, 1, "miss_l");
    end
    check("win_state", 32'(io.state), 32'(S_OVER));
    check("win_right", 32'(io.winner), 32'd2);
    act(0, 2, "restart");

    // Random walk over all event kinds, including ones that must be ignored.
    for (int i = 0; i < 250; i++) begin
      int kind;
      kind = int'($urandom_range(0, 6));
      if (m_state == S_SERVE && $urandom_range(0, 1) == 1) kind = 1;
      act(kind, int'($urandom_range(1, 3)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong game. It sits between the VGA timing, the ball/paddle datapath and the score display. It edge-detects start, miss and hit events and runs the match state machine: idle, serve countdown, rally, point and game over. It drives ball hold/run and serve direction, keeps both scores and the rally speed level, and declares the winner.

## Interface
Parameters:
- WIN_SCORE, 7, score that ends the match; legal range 1–15.
- SERVE_FRAMES, 60, frame ticks the ball is held before each serve; legal range 1–255.
- HITS_PER_LEVEL, 4, paddle hits per speed-level step; legal range 1–15.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  synchronous, active-low reset.
- frame_clk  in  1  VGA vertical sync, active low.
- start  in  1  start/restart request, level; the rising edge is the event.
- miss_l  in  1  ball passed the left boundary, level; the rising edge is the event.
- miss_r  in  1  ball passed the right boundary, level; the rising edge is the event.
- hit_l, hit_r  in  1 each  ball/paddle collision, level; the rising edge is the event.
- ball_hold  out  1  ball held at center when 1.
- serve_dir  out  1  0 = serve toward the right, 1 = serve toward the left.
- l_score, r_score  out  4 each  binary scores.
- speed_level  out  2  rally speed step, 0–3.
- winner  out  2  00 = none, 01 = left wins, 10 = right wins.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.

## Operation
- Input conditioning: each of frame_clk, start, miss_l, miss_r, hit_l and hit_r passes through one register stage, then an edge detector that compares it against its previous registered value.
- Frame tick: a one-cycle pulse on each falling edge of frame_clk.
- IDLE: ball_hold=1. A start event clears the scores and speed_level, sets serve_dir=0 and goes to SERVE.
- SERVE:
  - ball_hold=1.
  - The countdown is loaded with SERVE_FRAMES on entry and decrements on each frame tick.
  - A tick that finds the count at 1 moves to PLAY.
  - Miss and hit events are ignored.
- PLAY:
  - ball_hold=0.
  - miss_l event: r_score+1, serve_dir=1, go to POINT.
  - miss_r event: l_score+1, serve_dir=0, go to POINT.
  - Both in the same cycle: miss_l wins; miss_r is dropped.
  - A hit_l or hit_r event increments the rally counter (4-bit, saturates at 15).
  - speed_level = min(rally / HITS_PER_LEVEL, 3).
- POINT:
  - Lasts exactly one cycle. Clears the rally counter and speed_level.
  - If the score just incremented equals WIN_SCORE: set winner and go to GAMEOVER.
  - Otherwise go to SERVE.
- GAMEOVER:
  - ball_hold=1; scores and winner are held.
  - A start event clears scores and winner, sets serve_dir=0 and goes to SERVE.
- Start events are ignored in SERVE, PLAY and POINT.
- Scores never exceed WIN_SCORE, so no 4-bit wrap is possible.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, ball_hold=1, serve_dir=0, l_score=0, r_score=0, speed_level=0, winner=00, countdown=0, rally=0. Edge-detector history registers are also cleared.
- Reset_n low at any rising edge, including mid-rally or mid-countdown, reaches the reset values at that edge. Events pending in the pipeline are discarded.
- Event latency: an input rising edge sampled at Clk edge k updates state and outputs at edge k+2.
- Frame tick latency: 2 cycles after the frame_clk falling edge is sampled.
- Serve hold: exactly SERVE_FRAMES frame ticks from entering SERVE to PLAY. The first tick counts even if it arrives the cycle after entry.
- POINT → SERVE or GAMEOVER: 1 cycle.
- A level input held high produces exactly one event. It must go low and rise again to produce another.

## Configuration
- PONG_SPEEDUP_EN defined: rally counter and speed_level behave as in Operation.
- PONG_SPEEDUP_EN undefined: the rally counter is not built, hit_l/hit_r are unused, and speed_level is constant 0.

## Test plan
Test parameters: WIN_SCORE=3, SERVE_FRAMES=2, HITS_PER_LEVEL=2.

- Reset held low mid-PLAY with scores 2–1 → next edge: state=0, scores 0–0, ball_hold=1, winner=00.
- Start pulse in IDLE, then two frame_clk falling edges → SERVE 2 cycles after start, PLAY 2 cycles after the second tick, ball_hold drops to 0 with PLAY.
- In PLAY, miss_r held high for 100 cycles → l_score=1 exactly once, one POINT cycle, SERVE with serve_dir=0.
- miss_l and miss_r rising in the same cycle → r_score+1 only, serve_dir=1.
- Five hit_l/hit_r edges in one rally → speed_level goes 0→1 after hit 2 and 1→2 after hit 4. Then a miss → speed_level=0. With PONG_SPEEDUP_EN undefined: speed_level stays 0.
- Right wins 3–0 → GAMEOVER, winner=10, ball_hold=1. Start edge → SERVE, scores 0–0, winner=00, serve_dir=0.
